// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial LSB-first subtractor computing {B_O, D} = A - B - B_I
module serial_sub #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         B_I,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] D,
  output logic         B_O
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   a_sr, b_sr, d_sr;
  logic           borrow;
  logic [CW-1:0]  cnt;
  logic           diff_bit, borrow_nx, last_bit;

  assign diff_bit  = a_sr[0] ^ b_sr[0] ^ borrow;
  assign borrow_nx = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
  assign last_bit  = (cnt == LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    BUSY     = 1'b0;
    DONE     = 1'b0;
    case (state)
      IDLE: if (START) state_nx = RUN;
      RUN: begin
        BUSY = 1'b1;
        if (last_bit) state_nx = FIN;
      end
      FIN: begin
        BUSY     = 1'b1;
        DONE     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operands are only loaded in IDLE, so input activity while busy cannot disturb them.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_sr   <= '0;
      b_sr   <= '0;
      d_sr   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      D      <= '0;
      B_O    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            a_sr   <= A;
            b_sr   <= B;
            borrow <= B_I;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sr   <= {1'b0, a_sr[W-1:1]};
          b_sr   <= {1'b0, b_sr[W-1:1]};
          d_sr   <= {diff_bit, d_sr[W-1:1]};
          borrow <= borrow_nx;
          if (last_bit) begin
            // Counter is cleared rather than incremented so it never wraps.
            cnt <= '0;
            D   <= {diff_bit, d_sr[W-1:1]};
            B_O <= borrow_nx;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter: W, default 8, operand and result width in bits (W >= 2).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Port: CLK  input  1  rising-edge clock for all state.
REQ-004 Port: RST_N  input  1  asynchronous active-low reset.
REQ-005 Port: START  input  1  request to begin a subtraction; sampled on CLK rise.
REQ-006 Port: A  input  W  minuend; sampled only on an accepted START.
REQ-007 Port: B  input  W  subtrahend; sampled only on an accepted START.
REQ-008 Port: B_I  input  1  borrow-in; sampled only on an accepted START.
REQ-009 Port: BUSY  output  1  high while a subtraction is in progress.
REQ-010 Port: DONE  output  1  one-cycle pulse marking D and B_O valid.
REQ-011 Port: D  output  W  difference result.
REQ-012 Port: B_O  output  1  final borrow-out.

Function
REQ-013 The block SHALL compute {B_O, D} = A - B - B_I modulo 2^(W+1), with B_O = 1 exactly when A < B + B_I (unsigned).
REQ-014 The computation SHALL be bit-serial, LSB first: one full-subtractor step per RUN cycle, with a single borrow flip-flop.
- diff bit = a ^ b ^ borrow.
- next borrow = (~a & b) | (~(a ^ b) & borrow).
REQ-015 State machine states: IDLE, RUN, FIN. Reset state is IDLE.
REQ-016 IDLE -> RUN on a CLK rise with START=1.
- At that edge: capture A, B and B_I into internal shift registers and the borrow flop.
- Clear the bit counter to 0.
REQ-017 RUN: each CLK rise processes the current LSB of both shift registers.
- Shift the difference bit into the result register MSB-ward.
- Update the borrow flop.
- Increment the bit counter.
REQ-018 RUN -> FIN on the CLK rise that processes bit W-1, i.e. the W-th RUN edge after acceptance.
REQ-019 FIN -> IDLE on the next CLK rise, unconditionally.
REQ-020 Latency: START accepted at edge k means DONE=1 during the cycle following edge k+W, and 0 otherwise.
REQ-021 BUSY SHALL be 1 in RUN and FIN and 0 in IDLE.
REQ-022 D and B_O SHALL update only at the edge entering FIN.
- Their values hold until the next entry to FIN.
- They do not change during a subsequent RUN.
REQ-023 START SHALL be ignored in RUN and FIN; captured operands are unaffected by any input change while BUSY=1.
REQ-024 START high in FIN SHALL NOT be accepted. The earliest new acceptance is the edge leaving IDLE, so the minimum issue interval is W+2 cycles.
REQ-025 START held high continuously SHALL start a new operation on every IDLE cycle (back-to-back with one IDLE cycle between).
REQ-026 The bit counter SHALL be ceil(log2(W)) bits wide and SHALL never wrap within an operation.

Reset
REQ-027 RST_N=0 SHALL immediately force the following, regardless of CLK:
- state IDLE, BUSY=0, DONE=0;
- D=0, B_O=0, bit counter=0, borrow flop=0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no DONE pulse.
REQ-029 After RST_N deasserts, the first START SHALL be accepted normally.

Verification
REQ-030 W=8, A=0x05, B=0x03, B_I=0, START pulse -> DONE after 8 RUN edges, D=0x02, B_O=0; BUSY high 9 cycles.
REQ-031 A=0x00, B=0x01, B_I=0 -> D=0xFF, B_O=1. Also A=0x00, B=0x00, B_I=1 -> D=0xFF, B_O=1.
REQ-032 A=0xFF, B=0xFF, B_I=0 -> D=0x00, B_O=0. Then A=0x80, B=0x7F, B_I=1 -> D=0x00, B_O=0.
REQ-033 Start A=0x10, B=0x01; change A/B and pulse START during RUN -> D=0x0F, B_O=0, exactly one DONE pulse.
REQ-034 Assert RST_N=0 at the 4th RUN cycle -> BUSY, DONE, D, B_O all 0 immediately, no DONE. Then A=0x09, B=0x04 -> D=0x05.
REQ-035 START held high for 30 cycles with random A/B -> DONE every 10 cycles; each D/B_O matches a reference model of A-B-B_I.
